// File: rtl/turn_pkg.sv
// Shared types and constants for the turn/move controller slice.
package turn_pkg;

    localparam int BOARD_LEN   = 24;
    localparam int POS_W       = 5;
    localparam int MAX_PLAYERS = 4;

    typedef logic [1:0]       pidx_t;
    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        PASS  = 3'd4
    } state_t;

    // Effective player count: 3 and 4 are taken as-is, anything else plays as 2.
    function automatic logic [2:0] neff_of(input logic [3:0] n);
        logic [2:0] res;
        case (n)
            4'd3:    res = 3'd3;
            4'd4:    res = 3'd4;
            default: res = 3'd2;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/turn_move_ctrl_if.sv
// Bundle between the card-judging logic / position counters and the turn controller.
interface turn_move_ctrl_if;
    import turn_pkg::*;

    logic [3:0] N;
    logic       match;
    logic       miss;
    pos_t       p1_cnt;
    pos_t       p2_cnt;
    pos_t       p3_cnt;
    pos_t       p4_cnt;
    logic       p_da1;
    logic       p_da2;
    logic       p_da3;
    logic       p_da4;
    pidx_t      turn;
    logic       busy;
    logic       done;
    logic [1:0] hop_cnt;

    // Environment side: card judge plus position counters.
    modport master (
        output N, match, miss, p1_cnt, p2_cnt, p3_cnt, p4_cnt,
        input  p_da1, p_da2, p_da3, p_da4, turn, busy, done, hop_cnt
    );

    // Controller side.
    modport slave (
        input  N, match, miss, p1_cnt, p2_cnt, p3_cnt, p4_cnt,
        output p_da1, p_da2, p_da3, p_da4, turn, busy, done, hop_cnt
    );

endinterface

// File: rtl/tile_occupied_cmp.sv
// Combinational check: is the active player's tile shared with another active player?
module tile_occupied_cmp
    import turn_pkg::*;
(
    input  pos_t       p1_cnt,
    input  pos_t       p2_cnt,
    input  pos_t       p3_cnt,
    input  pos_t       p4_cnt,
    input  pidx_t      turn,
    input  logic [2:0] neff,
    output logic       occupied
);

    pos_t pos_s [MAX_PLAYERS];
    pos_t own_s;

    assign pos_s[0] = p1_cnt;
    assign pos_s[1] = p2_cnt;
    assign pos_s[2] = p3_cnt;
    assign pos_s[3] = p4_cnt;

    // OR together equality hits against every other player index below neff.
    always_comb begin
        own_s    = pos_s[turn];
        occupied = 1'b0;
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            occupied = occupied |
                       ((2'(i) != turn) && (i < int'(neff)) && (pos_s[i] == own_s));
        end
    end

endmodule

// File: rtl/turn_move_ctrl.sv
// Turn controller: steps the active player on a match, hops past occupied
// tiles (bounded by neff-1 hops) and hands the turn on after a miss.
module turn_move_ctrl
    import turn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    turn_move_ctrl_if.slave  bus
);

    state_t     state_r;
    pidx_t      turn_r;
    logic [3:0] p_da_r;
    logic       busy_r;
    logic       done_r;
    logic [1:0] hop_r;
    logic [2:0] neff_r;
    logic       hop_pending_r;

    logic [2:0] neff_now_s;
    logic [2:0] turn_wide_s;
    pidx_t      turn_next_s;
    pidx_t      turn_clamp_s;
    logic [3:0] strobe_s;
    logic       occupied_s;
    logic       hop_ok_s;

    tile_occupied_cmp u_cmp (
        .p1_cnt   (bus.p1_cnt),
        .p2_cnt   (bus.p2_cnt),
        .p3_cnt   (bus.p3_cnt),
        .p4_cnt   (bus.p4_cnt),
        .turn     (turn_r),
        .neff     (neff_r),
        .occupied (occupied_s)
    );

    // Next-turn, clamp, strobe select and hop decision derived from current state.
    always_comb begin
        neff_now_s   = neff_of(bus.N);
        turn_wide_s  = {1'b0, turn_r} + 3'd1;
        turn_next_s  = (turn_wide_s >= neff_now_s) ? 2'd0 : turn_wide_s[1:0];
        turn_clamp_s = ({1'b0, turn_r} >= neff_now_s) ? 2'd0 : turn_r;
        strobe_s     = 4'b0001 << turn_r;
        hop_ok_s     = occupied_s && ({1'b0, hop_r} < (neff_r - 3'd1));
    end

    // Main FSM; strobes and done are loaded on the edge entering their cycle
    // so that p_da lands in cycle 1 and done in the CHECK cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            turn_r        <= 2'd0;
            p_da_r        <= 4'b0000;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            hop_r         <= 2'd0;
            neff_r        <= 3'd2;
            hop_pending_r <= 1'b0;
        end else begin
            p_da_r <= 4'b0000;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.match) begin
                        state_r <= STEP;
                        busy_r  <= 1'b1;
                        hop_r   <= 2'd0;
                        neff_r  <= neff_now_s;
                        p_da_r  <= strobe_s;
                    end else if (bus.miss) begin
                        state_r <= PASS;
                        busy_r  <= 1'b1;
                        neff_r  <= neff_now_s;
                        turn_r  <= turn_next_s;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                STEP: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    state_r       <= CHECK;
                    hop_pending_r <= hop_ok_s;
                    done_r        <= !hop_ok_s;
                end
                CHECK: begin
                    if (hop_pending_r) begin
                        state_r <= STEP;
                        hop_r   <= hop_r + 2'd1;
                        p_da_r  <= strobe_s;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        turn_r  <= turn_clamp_s;
                    end
                end
                PASS: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    turn_r  <= turn_clamp_s;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.p_da1   = p_da_r[0];
    assign bus.p_da2   = p_da_r[1];
    assign bus.p_da3   = p_da_r[2];
    assign bus.p_da4   = p_da_r[3];
    assign bus.turn    = turn_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.hop_cnt = hop_r;

endmodule

// File: doc/turn_move_ctrl.md
Name: turn_move_ctrl

Overview:
- Turn controller that drives the per-player move strobes p_da1..p_da4 and reads back the 5-bit player positions p1_cnt..p4_cnt from the per-player position counters.
- Tracks whose turn it is and issues one step pulse on a card match.
- Issues extra hop pulses while the landing tile is occupied by another active player.
- Passes the turn on a miss.
- Sits between the card-judging logic and the position counters.

Parameters:
- BOARD_LEN, 24, number of tiles; positions 0..BOARD_LEN-1, counters wrap 23->0
- POS_W, 5, position width
- MAX_PLAYERS, 4, number of strobe/position channels

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- N  in  4  number of players; 2, 3 or 4, any other value treated as 2
- match  in  1  one-cycle pulse: active player's flipped card matched the next tile
- miss  in  1  one-cycle pulse: card did not match
- p1_cnt..p4_cnt  in  5 each  current positions from the counters
- p_da1..p_da4  out  1 each  registered one-cycle move strobes to the counters
- turn  out  2  active player index (0 = player 1)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a move sequence completes
- hop_cnt  out  2  number of hops in the last move sequence

Behaviour:
Single clock; reset is synchronous and active-high. All outputs registered.
Reset values: state=IDLE, turn=0, p_da1..4=0, busy=0, done=0, hop_cnt=0.

States:
- IDLE
  - match=1: go to STEP, clear the hop counter.
  - else miss=1: go to PASS.
  - match has priority if both are high in the same cycle.
  - Inputs are ignored in every state other than IDLE; no queuing.
- STEP
  - Assert p_da[turn+1]=1 for exactly this cycle; all other strobes 0.
  - Next state WAIT.
- WAIT
  - One cycle for the counter to register the step.
  - Next state CHECK.
- CHECK
  - Compare p[turn+1]_cnt with the positions of every other player index < Neff.
  - Any equal and hop_cnt < Neff-1: increment hop_cnt, go to STEP.
  - Otherwise: pulse done, go to IDLE; turn is unchanged, so the player keeps flipping.
- PASS
  - turn <= (turn+1) mod Neff.
  - Pulse done, go to IDLE.

Timing:
- Latency for a match with no collision: match sampled in cycle 0; p_da in cycle 1; done in cycle 3.
- Each hop adds 3 cycles.
- Miss: turn updates and done pulses in cycle 1.

Boundary conditions:
- Players with index >= Neff are never strobed and are excluded from the comparison.
- Wrap-around 23->0 is handled in the counters; the controller compares raw positions only.
- Hop cap of Neff-1 guarantees termination even if positions were already coincident at reset. At the cap, the sequence ends with done regardless of collision.
- If N changes while busy, the Neff latched on entering STEP or PASS is used until IDLE.
- turn >= new Neff on returning to IDLE: turn <= 0.
- rst mid-sequence: immediate return to reset values. Any strobe in flight is dropped, so at most one pulse is ever delivered per STEP.

Decomposition:
- Shared package turn_pkg:
  - state enum: IDLE, STEP, WAIT, CHECK, PASS
  - BOARD_LEN, POS_W, MAX_PLAYERS
  - player-index type (2 bits)
  - function mapping N to Neff (2/3/4)
- Sub-module tile_occupied_cmp (combinational):
  - inputs: four positions, turn, Neff
  - output: occupied flag

Test Plan:
- N=2, p1=0, p2=12, match pulse -> p_da1=1 in cycle 1 only, p_da2 never, done in cycle 3, turn=0, hop_cnt=0 (bench counter model: p1 ends 1).
- N=2, p1=11, p2=12, match -> two p_da1 pulses 3 cycles apart, p1 ends 13, hop_cnt=1, done in cycle 6.
- N=4, p1=0, p2=1, p3=2, p4=3, match -> three hops, p1 ends 4, hop_cnt=3, done in cycle 12.
- N=3, miss x4 -> turn 0->1->2->0->1, done each cycle 1 after the miss, no strobes.
- N=2, p1=23, match -> p1 wraps to 0, no collision with p2=12, done in cycle 3. Also: match and miss high together -> treated as match.
- rst asserted in STEP -> p_da1 low the next cycle, state IDLE, turn=0, busy=0. N=7 -> behaves as N=2, p_da3 and p_da4 never asserted.
